// File: rtl/pattern_step_sequencer.sv
// pattern_step_sequencer: phase sequencer for stepper-coil and LED-chaser pads.
// A phase pointer advances at a programmable divider rate (or one manual step per
// step_req cycle while disabled). It is decoded into a rotating N_OUT-bit pattern:
// one-hot full step, two-hot full step, or half step. All outputs are registered.
// Optional feature: define PSS_STEP_COUNT_EN to add step_cnt, a signed 32-bit net
// step count (+1 forward, -1 reverse), cleared by reset and by any accepted load.
module pattern_step_sequencer #(
   parameter  int N_OUT = 8,
   parameter  int DIV_W = 16,
   localparam int PH_W  = $clog2(2 * N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic             step_req,
   input  logic             load,
   input  logic [PH_W-1:0]  load_ph,
   output logic [N_OUT-1:0] q,
   output logic [PH_W-1:0]  ph,
   output logic             step_stb
`ifdef PSS_STEP_COUNT_EN
   ,
   output logic signed [31:0] step_cnt
`endif
);

   typedef enum logic [1:0] {
      MODE_ONE_HOT = 2'b00,
      MODE_TWO_HOT = 2'b01,
      MODE_HALF    = 2'b10,
      MODE_OFF     = 2'b11
   } mode_e;

   // Phase arithmetic runs one bit wider so ph + step and ph + 2*N_OUT never overflow.
   localparam int               NPH   = 2 * N_OUT;
   localparam logic [PH_W:0]    NPH_X = NPH[PH_W:0];
   localparam logic [PH_W:0]    STEP1 = {{PH_W{1'b0}}, 1'b1};
   localparam logic [PH_W:0]    STEP2 = {{(PH_W-1){1'b0}}, 2'b10};
   localparam logic [N_OUT-1:0] ONE   = {{(N_OUT-1){1'b0}}, 1'b1};

   mode_e mode_s;
   assign mode_s = mode_e'(mode);

   // Pattern decode. Position k lights bit (N_OUT-1-k) mod N_OUT. The companion bit of
   // a two-hot pair is the lead bit rotated one place toward the LSB, so p = N_OUT-1
   // naturally gives MSB|LSB.
   function automatic logic [N_OUT-1:0] pat_f(input logic [PH_W-1:0] ph_i, input mode_e mode_i);
      logic [PH_W-1:0]  p;
      logic [N_OUT-1:0] lead;
      logic [N_OUT-1:0] trail;
      p     = ph_i >> 1;
      lead  = ONE << (N_OUT - 1 - int'(p));
      trail = {lead[0], lead[N_OUT-1:1]};
      case (mode_i)
         MODE_ONE_HOT: pat_f = lead;
         MODE_TWO_HOT: pat_f = lead | trail;
         MODE_HALF:    pat_f = ph_i[0] ? (lead | trail) : lead;
         default:      pat_f = '0;
      endcase
   endfunction

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [N_OUT-1:0] q_q, q_d;
   logic             step_stb_q, step_stb_d;
`ifdef PSS_STEP_COUNT_EN
   logic signed [31:0] step_cnt_q, step_cnt_d;
`endif

   logic          tick;
   logic          step_ev;
   logic          load_ok;
   logic [PH_W:0] ph_ext;
   logic [PH_W:0] delta;
   logic [PH_W:0] ph_sum;
   logic [PH_W:0] ph_fwd;
   logic [PH_W:0] ph_rev;

   // Divider, step/load arbitration, modulo-2N phase update and next pad pattern.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      cnt_d      = cnt_q;
      ph_d       = ph_q;
      step_stb_d = 1'b0;
`ifdef PSS_STEP_COUNT_EN
      step_cnt_d = step_cnt_q;
`endif

      // >= rather than == so a div lowered below the running count ticks on the next cycle.
      tick    = en && (cnt_q >= div);
      step_ev = en ? tick : step_req;
      load_ok = load && ({1'b0, load_ph} < NPH_X);

      // Full-step modes move by 2 and keep ph[0]; half step moves by 1.
      ph_ext = {1'b0, ph_q};
      delta  = (mode_s == MODE_HALF) ? STEP1 : STEP2;
      ph_sum = ph_ext + delta;
      ph_fwd = (ph_sum >= NPH_X) ? (ph_sum - NPH_X) : ph_sum;
      ph_rev = (ph_ext < delta) ? (ph_ext + NPH_X - delta) : (ph_ext - delta);

      if (!en || load || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      // Any load (even an out-of-range one) pre-empts a coincident step.
      if (load) begin
         if (load_ok) begin
            ph_d = load_ph;
`ifdef PSS_STEP_COUNT_EN
            step_cnt_d = '0;
`endif
         end
      end else if (step_ev && (mode_s != MODE_OFF)) begin
         ph_d       = dir ? ph_rev[PH_W-1:0] : ph_fwd[PH_W-1:0];
         step_stb_d = 1'b1;
`ifdef PSS_STEP_COUNT_EN
         step_cnt_d = dir ? (step_cnt_q - 32'sd1) : (step_cnt_q + 32'sd1);
`endif
      end

      // The pattern follows the new phase and the current mode on the same edge.
      q_d = pat_f(ph_d, mode_s);
   end

   // State registers; reset clears the pads immediately, without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         ph_q       <= '0;
         q_q        <= '0;
         step_stb_q <= 1'b0;
`ifdef PSS_STEP_COUNT_EN
         step_cnt_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         q_q        <= q_d;
         step_stb_q <= step_stb_d;
`ifdef PSS_STEP_COUNT_EN
         step_cnt_q <= step_cnt_d;
`endif
      end
   end

   assign q        = q_q;
   assign ph       = ph_q;
   assign step_stb = step_stb_q;
`ifdef PSS_STEP_COUNT_EN
   assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_step_sequencer.sv
// tb_pattern_step_sequencer: scoreboard bench for pattern_step_sequencer.
// Two instances share all inputs: N_OUT=8 (power-of-two phase range) and N_OUT=5
// (phase range 0..9, so out-of-range loads are reachable). A behavioural model
// predicts each edge and queues the expectation; a negedge monitor pops and compares.
// Define PSS_STEP_COUNT_EN to also check step_cnt.
module tb_pattern_step_sequencer;

   localparam int N_A = 8;
   localparam int N_B = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        dir;
   logic        step_req;
   logic        load;
   logic [1:0]  mode;
   logic [15:0] div;
   logic [3:0]  load_ph;

   logic [7:0]  q_a;
   logic [3:0]  ph_a;
   logic        stb_a;
   logic [4:0]  q_b;
   logic [3:0]  ph_b;
   logic        stb_b;
`ifdef PSS_STEP_COUNT_EN
   logic signed [31:0] sc_a;
   logic signed [31:0] sc_b;
`endif

   typedef struct packed {
      logic [7:0]  q;
      logic [3:0]  ph;
      logic        stb;
      logic [31:0] sc;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];

   int m_ph[2];
   int m_cnt[2];
   int m_sc[2];

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] t1_tab[8] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};
   logic [7:0] t3_tab[3] = '{8'hC0, 8'h40, 8'h60};

   always #5 clk = ~clk;

   pattern_step_sequencer #(.N_OUT(N_A), .DIV_W(16)) dut_a (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
      .step_req(step_req), .load(load), .load_ph(load_ph),
      .q(q_a), .ph(ph_a), .step_stb(stb_a)
`ifdef PSS_STEP_COUNT_EN
      , .step_cnt(sc_a)
`endif
   );

   pattern_step_sequencer #(.N_OUT(N_B), .DIV_W(16)) dut_b (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
      .step_req(step_req), .load(load), .load_ph(load_ph),
      .q(q_b), .ph(ph_b), .step_stb(stb_b)
`ifdef PSS_STEP_COUNT_EN
      , .step_cnt(sc_b)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Pattern as a rotation: build the pattern for position 0 (MSB-aligned) and rotate
   // it right by p positions.
   function automatic logic [7:0] model_pat(input int n, input int phase, input int md);
      logic [7:0] base;
      logic [7:0] r;
      int p;
      if (md == 3) return 8'h00;
      p    = phase / 2;
      base = 8'h01 << (n - 1);
      if (md == 1 || (md == 2 && (phase % 2) == 1)) base = base | (8'h01 << (n - 2));
      r = 8'h00;
      for (int j = 0; j < n; j++) begin
         if (((base >> ((j + p) % n)) & 8'h01) != 8'h00) r = r | (8'h01 << j);
      end
      return r;
   endfunction

   // One clock edge of the reference behaviour for instance i; queues its expectation.
   task automatic model_edge(input int i);
      int   n;
      int   np;
      int   d;
      bit   tick;
      bit   ev;
      bit   stb;
      exp_t e;
      n    = (i == 0) ? N_A : N_B;
      np   = 2 * n;
      tick = en && (m_cnt[i] >= int'(div));
      ev   = en ? tick : step_req;
      stb  = 1'b0;
      if (load) begin
         if (int'(load_ph) < np) begin
            m_ph[i] = int'(load_ph);
            m_sc[i] = 0;
         end
      end else if (ev && mode != 2'b11) begin
         d       = (mode == 2'b10) ? 1 : 2;
         m_ph[i] = dir ? (m_ph[i] - d + np) % np : (m_ph[i] + d) % np;
         m_sc[i] = dir ? m_sc[i] - 1 : m_sc[i] + 1;
         stb     = 1'b1;
      end
      m_cnt[i] = (!en || load || tick) ? 0 : m_cnt[i] + 1;
      e.q   = model_pat(n, m_ph[i], int'(mode));
      e.ph  = m_ph[i][3:0];
      e.stb = stb;
      e.sc  = m_sc[i];
      if (i == 0) sb_a.push_back(e);
      else        sb_b.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i]  = 0;
         m_cnt[i] = 0;
         m_sc[i]  = 0;
      end
   endtask

   // Advance one edge with the inputs already driven; returns 1 time unit after the edge.
   task automatic cycle();
      @(posedge clk);
      if (!rst) begin
         model_edge(0);
         model_edge(1);
      end
      #1;
   endtask

   // Assert reset between edges and check the pads clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_async_q_a", 32'(q_a), 32'h0);
      check("rst_async_q_b", 32'(q_b), 32'h0);
      check("rst_async_ph_a", 32'(ph_a), 32'h0);
      check("rst_async_stb_a", 32'(stb_a), 32'h0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   // Monitor: every cycle the oldest expectation per instance is compared with the outputs.
   always @(negedge clk) begin
      exp_t e;
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         check("sb_q_a", 32'(q_a), 32'(e.q));
         check("sb_ph_a", 32'(ph_a), 32'(e.ph));
         check("sb_stb_a", 32'(stb_a), 32'(e.stb));
`ifdef PSS_STEP_COUNT_EN
         check("sb_step_cnt_a", sc_a, e.sc);
`endif
      end
      if (sb_b.size() > 0) begin
         e = sb_b.pop_front();
         check("sb_q_b", 32'(q_b), 32'(e.q));
         check("sb_ph_b", 32'(ph_b), 32'(e.ph));
         check("sb_stb_b", 32'(stb_b), 32'(e.stb));
`ifdef PSS_STEP_COUNT_EN
         check("sb_step_cnt_b", sc_b, e.sc);
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run still active at t=%0t, limit 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int stb_seen;
      rst = 1'b1; en = 1'b0; dir = 1'b0; step_req = 1'b0; load = 1'b0;
      mode = 2'b01; div = 16'd0; load_ph = 4'd0;
      model_reset();

      // Reset state, then the first edge just loads pat(0, two-hot).
      #3;
      check("reset_q_a", 32'(q_a), 32'h0);
      check("reset_ph_a", 32'(ph_a), 32'h0);
      check("reset_stb_a", 32'(stb_a), 32'h0);
      #9 rst = 1'b0;
      cycle();
      check("first_q_a", 32'(q_a), 32'hC0);

      // Two-hot forward at div=0: one step per cycle, wrapping through MSB|LSB.
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("t1_q_a", 32'(q_a), 32'(t1_tab[i]));
      end

      // One manual reverse step from ph=0 wraps to ph=14.
      en = 1'b0; load = 1'b1; load_ph = 4'd0;
      cycle();
      load = 1'b0; dir = 1'b1; step_req = 1'b1;
      cycle();
      check("t2_q_a", 32'(q_a), 32'h81);
      check("t2_ph_a", 32'(ph_a), 32'd14);
      check("t2_stb_a", 32'(stb_a), 32'h1);
      step_req = 1'b0;
      cycle();
      check("t2_stb_drop_a", 32'(stb_a), 32'h0);

      // Half step forward from ph=0; the loading edge itself does not step.
      mode = 2'b10; dir = 1'b0; en = 1'b1; load = 1'b1; load_ph = 4'd0;
      cycle();
      check("t3_load_q_a", 32'(q_a), 32'h80);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t3_q_a", 32'(q_a), 32'(t3_tab[i]));
         check("t3_ph_a", 32'(ph_a), 32'(i + 1));
      end

      // Reset mid-run with a lit pattern.
      do_reset();
      check("rst_release_q_a", 32'(q_a), 32'h0);

      // div=3: a step every 4th edge; after en drops, the next step is 4 edges after en rises.
      mode = 2'b01; dir = 1'b0; div = 16'd3; en = 1'b1;
      stb_seen = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (stb_a) stb_seen++;
      end
      check("t4_stb_count_a", 32'(stb_seen), 32'd3);
      en = 1'b0;
      cycle();
      cycle();
      en = 1'b1;
      k = 0;
      stb_seen = 0;
      while (k < 10 && stb_seen == 0) begin
         cycle();
         k++;
         if (stb_a) stb_seen = 1;
      end
      check("t4_restart_latency_a", 32'(k), 32'd4);

      // Load coincident with a tick wins and raises no strobe; ph=6 -> p=3 -> bits 4,3.
      div = 16'd0; load = 1'b1; load_ph = 4'd6;
      cycle();
      check("t5_ph_a", 32'(ph_a), 32'd6);
      check("t5_q_a", 32'(q_a), 32'h18);
      check("t5_stb_a", 32'(stb_a), 32'h0);
      // 12 is in range for N_OUT=8 but not for N_OUT=5, whose phase must stay at 6.
      load_ph = 4'd12;
      cycle();
      check("t5_ph_a_valid", 32'(ph_a), 32'd12);
      check("t5_ph_b_ignored", 32'(ph_b), 32'd6);
      check("t5_stb_b", 32'(stb_b), 32'h0);
      load = 1'b0;

      // Outputs off while running: pads dark, phase frozen.
      mode = 2'b11;
      for (int i = 0; i < 4; i++) cycle();
      check("t6_q_a", 32'(q_a), 32'h0);
      check("t6_ph_a", 32'(ph_a), 32'd12);
      check("t6_stb_a", 32'(stb_a), 32'h0);

      // Net step count: 5 forward then 2 reverse manual steps after a clearing load.
      mode = 2'b01; en = 1'b0; load = 1'b1; load_ph = 4'd0;
      cycle();
      load = 1'b0; step_req = 1'b1; dir = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      dir = 1'b1;
      for (int i = 0; i < 2; i++) cycle();
      step_req = 1'b0;
      cycle();
      check("t6_ph_a_after_steps", 32'(ph_a), 32'd6);
`ifdef PSS_STEP_COUNT_EN
      check("t6_step_cnt_a", sc_a, 32'sd3);
      check("t6_step_cnt_b", sc_b, 32'sd3);
`endif

      // Randomised run against the model, with occasional mid-run resets.
      for (int i = 0; i < 2000; i++) begin
         en       = ($urandom_range(0, 9) < 7);
         dir      = 1'($urandom_range(0, 1));
         step_req = 1'($urandom_range(0, 1));
         div      = 16'($urandom_range(0, 4));
         load     = ($urandom_range(0, 15) == 0);
         load_ph  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         if (i % 700 == 350) do_reset();
         cycle();
      end

      // Drain the scoreboard within a bounded number of cycles.
      k = 0;
      while (k < 10 && (sb_a.size() > 0 || sb_b.size() > 0)) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("drain_a", 32'(sb_a.size()), 32'd0);
      check("drain_b", 32'(sb_b.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
